// File: rtl/ir_nec_pkg.sv
// NEC infrared decoder shared types: FSM encoding, default timing windows
// (50 MHz counts) and frame helpers.
package ir_nec_pkg;

  localparam int CNT_W = 19;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SPACE = 2'd2,
    ST_DATA  = 2'd3
  } ir_state_t;

  localparam int NEC_LEAD_MIN = 425000;
  localparam int NEC_LEAD_MAX = 475000;
  localparam int NEC_SPC_MIN  = 200000;
  localparam int NEC_SPC_MAX  = 250000;
  localparam int NEC_REP_MIN  = 100000;
  localparam int NEC_REP_MAX  = 125000;
  localparam int NEC_T0_MIN   = 20000;
  localparam int NEC_T0_MAX   = 35000;
  localparam int NEC_T1_MIN   = 75000;
  localparam int NEC_T1_MAX   = 95000;
  localparam int NEC_TIMEOUT  = 500000;

  // Bits arrive LSB-first, so byte0 (address) lands in the low byte.
  typedef struct packed {
    logic [7:0] cmd_n;
    logic [7:0] cmd;
    logic [7:0] addr_n;
    logic [7:0] addr;
  } nec_frame_t;

  function automatic logic frame_ok(input nec_frame_t f);
    return (f.addr_n == ~f.addr) && (f.cmd_n == ~f.cmd);
  endfunction

  function automatic logic in_win(input logic [CNT_W-1:0] c,
                                  input logic [CNT_W-1:0] lo,
                                  input logic [CNT_W-1:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/ir_edge_sync.sv
// Two-flop synchroniser for the IR line plus one delay stage; registered
// rise/fall strobes, all flops reset high so release never looks like a fall.
module ir_edge_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic infrared_in,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic       dly;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sync <= 2'b11;
      dly  <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], infrared_in};
      dly  <= sync[1];
      rise <= sync[1] & ~dly;
      fall <= ~sync[1] & dly;
    end
  end

endmodule

// File: rtl/infrared_rcv.sv
// NEC infrared receiver: measures low/high durations between line edges,
// decodes 32-bit frames and repeat codes, and pulses data_valid / repeat_en.
module infrared_rcv
  import ir_nec_pkg::*;
#(
  parameter int CNT_LEAD_MIN = NEC_LEAD_MIN,
  parameter int CNT_LEAD_MAX = NEC_LEAD_MAX,
  parameter int CNT_SPC_MIN  = NEC_SPC_MIN,
  parameter int CNT_SPC_MAX  = NEC_SPC_MAX,
  parameter int CNT_REP_MIN  = NEC_REP_MIN,
  parameter int CNT_REP_MAX  = NEC_REP_MAX,
  parameter int CNT_T0_MIN   = NEC_T0_MIN,
  parameter int CNT_T0_MAX   = NEC_T0_MAX,
  parameter int CNT_T1_MIN   = NEC_T1_MIN,
  parameter int CNT_T1_MAX   = NEC_T1_MAX,
  parameter int CNT_TIMEOUT  = NEC_TIMEOUT
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       infrared_in,
  output logic       repeat_en,
  output logic       data_valid,
  output logic [7:0] addr,
  output logic [7:0] data
);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t LEAD_LO = cnt_t'(CNT_LEAD_MIN);
  localparam cnt_t LEAD_HI = cnt_t'(CNT_LEAD_MAX);
  localparam cnt_t SPC_LO  = cnt_t'(CNT_SPC_MIN);
  localparam cnt_t SPC_HI  = cnt_t'(CNT_SPC_MAX);
  localparam cnt_t REP_LO  = cnt_t'(CNT_REP_MIN);
  localparam cnt_t REP_HI  = cnt_t'(CNT_REP_MAX);
  localparam cnt_t T0_LO   = cnt_t'(CNT_T0_MIN);
  localparam cnt_t T0_HI   = cnt_t'(CNT_T0_MAX);
  localparam cnt_t T1_LO   = cnt_t'(CNT_T1_MIN);
  localparam cnt_t T1_HI   = cnt_t'(CNT_T1_MAX);
  localparam cnt_t TMO     = cnt_t'(CNT_TIMEOUT);

  logic       rise, fall;
  cnt_t       cnt;
  ir_state_t  state, state_nxt;
  logic [5:0] bit_cnt;
  logic [31:0] shift_reg;
  nec_frame_t frame_nxt;
  logic       frame_seen;

  logic win_lead, win_spc, win_rep, win_t0, win_t1, timeout;
  logic shift_en, bit_val, bit_clr, rep_set, dv_set;

  ir_edge_sync u_sync (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .infrared_in(infrared_in),
    .rise       (rise),
    .fall       (fall)
  );

  // Duration of the current line level; saturates so long idles stay large.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)        cnt <= '0;
    else if (rise || fall) cnt <= '0;
    else if (cnt != '1)    cnt <= cnt + cnt_t'(1);
  end

  assign win_lead = in_win(cnt, LEAD_LO, LEAD_HI);
  assign win_spc  = in_win(cnt, SPC_LO, SPC_HI);
  assign win_rep  = in_win(cnt, REP_LO, REP_HI);
  assign win_t0   = in_win(cnt, T0_LO, T0_HI);
  assign win_t1   = in_win(cnt, T1_LO, T1_HI);
  assign timeout  = (state != ST_IDLE) && (cnt >= TMO);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (fall) state_nxt = ST_LEAD;
        ST_LEAD:  if (rise) state_nxt = win_lead ? ST_SPACE : ST_IDLE;
        ST_SPACE: if (fall) state_nxt = win_spc ? ST_DATA : ST_IDLE;
        ST_DATA: begin
          if (rise && !win_t0)                          state_nxt = ST_IDLE;
          else if (fall && !(win_t0 || win_t1))         state_nxt = ST_IDLE;
          else if (fall && bit_cnt == 6'd31)            state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bit_val  = win_t1;
    shift_en = !timeout && (state == ST_DATA) && fall && (win_t0 || win_t1);
    bit_clr  = !timeout && (state == ST_SPACE) && fall && win_spc;
    rep_set  = !timeout && (state == ST_SPACE) && fall && win_rep && frame_seen;
    frame_nxt = nec_frame_t'({bit_val, shift_reg[31:1]});
    dv_set   = shift_en && (bit_cnt == 6'd31) && frame_ok(frame_nxt);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      frame_seen <= 1'b0;
      repeat_en  <= 1'b0;
      data_valid <= 1'b0;
      addr       <= 8'h00;
      data       <= 8'h00;
    end else begin
      repeat_en  <= rep_set;
      data_valid <= dv_set;
      if (bit_clr) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        shift_reg <= frame_nxt;
        bit_cnt   <= bit_cnt + 6'd1;
      end
      if (dv_set) begin
        addr       <= frame_nxt.addr;
        data       <= frame_nxt.cmd;
        frame_seen <= 1'b1;
      end
    end
  end

endmodule

// File: doc/infrared_rcv.md
INFRARED_RCV -- requirements
Module: infrared_rcv

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: sys_clk and sys_rst_n.
REQ-002 Parameters (counts at 50 MHz), one per line: name, default, meaning:
- CNT_LEAD_MIN 425000, minimum lead-low length (8.5 ms).
- CNT_LEAD_MAX 475000, maximum lead-low length (9.5 ms).
- CNT_SPC_MIN 200000, minimum data-space length (4.0 ms).
- CNT_SPC_MAX 250000, maximum data-space length (5.0 ms).
- CNT_REP_MIN 100000, minimum repeat-space length (2.0 ms).
- CNT_REP_MAX 125000, maximum repeat-space length (2.5 ms).
- CNT_T0_MIN 20000, minimum 560 us slot (0.4 ms).
- CNT_T0_MAX 35000, maximum 560 us slot (0.7 ms).
- CNT_T1_MIN 75000, minimum 1690 us slot (1.5 ms).
- CNT_T1_MAX 95000, maximum 1690 us slot (1.9 ms).
- CNT_TIMEOUT 500000, abort threshold (10 ms).
REQ-003 Ports, one per line: name, direction, width, meaning:
- sys_clk, in, 1, clock, 50 MHz.
- sys_rst_n, in, 1, synchronous active-low reset.
- infrared_in, in, 1, asynchronous IR receiver output; active-low; idles high.
- repeat_en, out, 1, one-cycle pulse on a valid NEC repeat code.
- data_valid, out, 1, one-cycle pulse when a frame passes the checks.
- addr, out, 8, last valid address byte.
- data, out, 8, last valid command byte.

Function
REQ-004 The block SHALL synchronise infrared_in through two flops, register the synchronised value once more, and derive one-cycle rise and fall strobes from that pair.
REQ-005 A 19-bit duration counter SHALL clear to 0 on any rise or fall strobe, otherwise increment, and saturate at its maximum value.
REQ-006 The FSM SHALL have the states IDLE, LEAD, SPACE and DATA.
REQ-007 IDLE: on fall, the FSM SHALL go to LEAD.
REQ-008 LEAD: on rise, the FSM SHALL go to SPACE if the count is within [CNT_LEAD_MIN, CNT_LEAD_MAX], otherwise to IDLE.
REQ-009 SPACE: on fall, the FSM SHALL do the following:
- Count within the SPC window: go to DATA and clear bit_cnt.
- Count within the REP window: pulse repeat_en the next cycle if a valid frame has been received since reset, then go to IDLE.
- Otherwise: go to IDLE.
REQ-010 DATA, on rise: if the low period is outside the T0 window, the FSM SHALL go to IDLE.
REQ-011 DATA, on fall: the high period SHALL decode as bit 0 in the T0 window, as bit 1 in the T1 window, and otherwise abort to IDLE.
REQ-012 Each decoded bit SHALL shift in LSB-first, shift_reg <= {bit, shift_reg[31:1]}, and bit_cnt SHALL increment (6-bit).
REQ-013 On the 32nd decoded bit the FSM SHALL return to IDLE and evaluate the frame, with byte0 = addr, byte1 = ~addr, byte2 = cmd, byte3 = ~cmd.
REQ-014 If byte1 == ~byte0 and byte3 == ~byte2, the block SHALL load addr and data and pulse data_valid in the cycle after the 32nd-bit fall strobe.
REQ-015 If either byte check fails, the frame SHALL be silently discarded, with addr and data unchanged.
REQ-016 In any non-IDLE state, when the count reaches CNT_TIMEOUT, the FSM SHALL return to IDLE with no output pulse.
REQ-017 addr and data SHALL hold their values between frames; a repeat code SHALL NOT alter them.
REQ-018 repeat_en and data_valid SHALL never assert in the same cycle, and each pulse SHALL be exactly one cycle wide.
REQ-019 The end-to-end latency SHALL be 3 cycles from the infrared_in edge to the strobe, plus 1 cycle to the output pulse.

Reset
REQ-020 While sys_rst_n=0 at a clock edge, the following SHALL hold:
- Sync and edge registers = 1, so no false fall occurs at release.
- Counter = 0, FSM = IDLE, bit_cnt = 0, shift_reg = 0.
- The valid-frame-seen flag = 0.
- repeat_en = 0, data_valid = 0, addr = 8'h00, data = 8'h00.
REQ-021 A reset asserted mid-frame SHALL abort the frame and produce no pulse; decoding SHALL restart on the next lead.

Structure
REQ-022 Package ir_nec_pkg SHALL hold the FSM state encoding and the timing-window constants; infrared_rcv parameters SHALL default from it.
REQ-023 Sub-module ir_edge_sync SHALL contain the two-flop synchroniser, the delay register and the rise/fall strobes.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Nominal NEC frame addr=8'h00, cmd=8'h45 -> one data_valid pulse; addr=00, data=45; repeat_en stays 0.
- The same frame followed by a repeat code 40 ms later (9 ms low, 2.25 ms high, 560 us low) -> one repeat_en pulse; addr and data unchanged.
- A repeat code as the first activity after reset -> no repeat_en.
- A frame with byte3 corrupted (cmd=45, ~cmd=BB) -> no data_valid; the previous addr and data are held.
- Lead low of 7 ms, or a line stuck low for 12 ms mid-frame -> return to IDLE with no pulses; the next nominal frame (cmd=8'h16) decodes correctly.
- sys_rst_n pulsed low after bit 10 -> outputs return to their reset values; no pulse; the following frame decodes.
